power_sequencer: RTL and testbench



---
 rtl/power_sequencer.sv | 137 +++++++++++++
 tb/tb_power_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// Power-on sequencer: debounces a power request, starts the voltage monitor,
// waits for it to report power-on, retries with backoff on timeout or
// brownout, and latches a fault once the retry budget is used up.
//
// state    | meaning
// ---------+----------------------------------------------------------
// OFF      | idle, monitor disabled, retry count cleared
// DEBOUNCE | pwr_req must stay high for DEBOUNCE_CYCLES
// START    | monitor enabled, waiting up to SETTLE_CYCLES for mon_on
// ON       | power up and stable, pwr_good asserted
// BACKOFF  | monitor held off for BACKOFF_CYCLES before the next try
// FAULT    | retries exhausted, waits for clear_fault with pwr_req low
//
// Parameters must be >= 1; the three cycle counts must be <= 2**24.
module power_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SETTLE_CYCLES   = 500000,
  parameter int unsigned BACKOFF_CYCLES  = 2500000,
  parameter int unsigned MAX_RETRIES     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pwr_req,
  input  logic       pwr_off,
  input  logic       clear_fault,
  input  logic       mon_on,
  output logic       mon_start,
  output logic       pwr_good,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DEBOUNCE = 3'd1,
    S_START    = 3'd2,
    S_ON       = 3'd3,
    S_BACKOFF  = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  // Terminal counts; the counter runs from 0 up to N-1.
  localparam logic [23:0] DEB_LAST    = 24'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] BACKOFF_LAST = 24'(BACKOFF_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [23:0] cnt;
  logic [23:0] cnt_next;
  logic        retry_inc;
  logic [3:0]  retry_next;
  logic        retries_spent;

  assign retries_spent = 32'(retry_count) >= MAX_RETRIES;

  // Next-state decode; pwr_off overrides everything except a latched fault.
  always_comb begin
    next_state = state;
    retry_inc  = 1'b0;
    case (state)
      S_OFF: begin
        if (pwr_req) next_state = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!pwr_req)             next_state = S_OFF;
        else if (cnt == DEB_LAST) next_state = S_START;
      end
      S_START: begin
        if (mon_on) begin
          next_state = S_ON;
        end else if (cnt == SETTLE_LAST) begin
          next_state = S_BACKOFF;
          retry_inc  = 1'b1;
        end
      end
      S_ON: begin
        if (!pwr_req) begin
          next_state = S_OFF;
        end else if (!mon_on) begin
          next_state = S_BACKOFF;
          retry_inc  = 1'b1;
        end
      end
      S_BACKOFF: begin
        if (cnt == BACKOFF_LAST) begin
          if (retries_spent) next_state = S_FAULT;
          else               next_state = S_START;
        end
      end
      S_FAULT: begin
        if (clear_fault && !pwr_req) next_state = S_OFF;
      end
      default: next_state = S_OFF;
    endcase
    if (pwr_off && state != S_FAULT) begin
      next_state = S_OFF;
      retry_inc  = 1'b0;
    end
  end

  // Counter and retry bookkeeping for the next cycle.
  always_comb begin
    cnt_next = 24'd0;
    if (next_state == state &&
        (state == S_DEBOUNCE || state == S_START || state == S_BACKOFF))
      cnt_next = cnt + 24'd1;
    retry_next = retry_count;
    if (next_state == S_OFF)
      retry_next = 4'd0;
    else if (retry_inc && retry_count != 4'hF)
      retry_next = retry_count + 4'd1;
  end

  // State, counter and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_OFF;
      cnt         <= 24'd0;
      retry_count <= 4'd0;
      mon_start   <= 1'b0;
      pwr_good    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_next;
      retry_count <= retry_next;
      mon_start   <= (next_state == S_START) || (next_state == S_ON);
      pwr_good    <= (next_state == S_ON);
      fault       <= (next_state == S_FAULT);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_power_sequencer.sv
// Directed bench for power_sequencer with short timer parameters.
module tb_power_sequencer;

  logic       clk;
  logic       reset_n;
  logic       pwr_req;
  logic       pwr_off;
  logic       clear_fault;
  logic       mon_on;
  logic       mon_start;
  logic       pwr_good;
  logic       fault;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  int total_cnt = 0;
  int pass_cnt  = 0;

  power_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES  (8),
    .BACKOFF_CYCLES (6),
    .MAX_RETRIES    (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pwr_req    (pwr_req),
    .pwr_off    (pwr_off),
    .clear_fault(clear_fault),
    .mon_on     (mon_on),
    .mon_start  (mon_start),
    .pwr_good   (pwr_good),
    .fault      (fault),
    .retry_count(retry_count),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed tuple: {state, mon_start, pwr_good, fault, retry_count}
  wire [9:0] obs = {state_dbg, mon_start, pwr_good, fault, retry_count};

  function automatic logic [9:0] mk(input logic [2:0] st, input logic ms,
                                    input logic pg, input logic f,
                                    input logic [3:0] rc);
    return {st, ms, pg, f, rc};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; pwr_req = 1'b0; pwr_off = 1'b0;
    clear_fault = 1'b0; mon_on = 1'b0;
    tick(2);
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL reset_state: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
    reset_n = 1'b1;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL reset_release_idle: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
  endtask

  task automatic test_normal_powerup;
    pwr_req = 1'b1;
    tick(4);
    total_cnt++;
    if (obs !== mk(3'd1, 0, 0, 0, 4'd0))
      $display("FAIL pu_debounce_edge4: got %h exp %h", obs, mk(3'd1, 0, 0, 0, 4'd0));
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd2, 1, 0, 0, 4'd0))
      $display("FAIL pu_start_edge5: got %h exp %h", obs, mk(3'd2, 1, 0, 0, 4'd0));
    else pass_cnt++;
    tick(3);
    mon_on = 1'b1;
    total_cnt++;
    if (obs !== mk(3'd2, 1, 0, 0, 4'd0))
      $display("FAIL pu_still_start: got %h exp %h", obs, mk(3'd2, 1, 0, 0, 4'd0));
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd3, 1, 1, 0, 4'd0))
      $display("FAIL pu_on: got %h exp %h", obs, mk(3'd3, 1, 1, 0, 4'd0));
    else pass_cnt++;
    pwr_req = 1'b0; mon_on = 1'b0;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL pu_release_off: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
  endtask

  task automatic test_glitch;
    logic seen_start;
    seen_start = 1'b0;
    pwr_req = 1'b1;
    tick(2);
    total_cnt++;
    if (state_dbg !== 3'd1)
      $display("FAIL glitch_in_debounce: got %0d exp %0d", state_dbg, 3'd1);
    else pass_cnt++;
    pwr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (mon_start) seen_start = 1'b1;
    end
    total_cnt++;
    if (seen_start !== 1'b0)
      $display("FAIL glitch_mon_start: got %0b exp %0b", seen_start, 1'b0);
    else pass_cnt++;
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL glitch_back_off: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
  endtask

  task automatic test_retry_exhaustion;
    pwr_req = 1'b1; mon_on = 1'b0;
    tick(5);
    total_cnt++;
    if (obs !== mk(3'd2, 1, 0, 0, 4'd0))
      $display("FAIL rx_start1: got %h exp %h", obs, mk(3'd2, 1, 0, 0, 4'd0));
    else pass_cnt++;
    tick(7);
    total_cnt++;
    if (obs !== mk(3'd2, 1, 0, 0, 4'd0))
      $display("FAIL rx_start1_last: got %h exp %h", obs, mk(3'd2, 1, 0, 0, 4'd0));
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd4, 0, 0, 0, 4'd1))
      $display("FAIL rx_backoff1: got %h exp %h", obs, mk(3'd4, 0, 0, 0, 4'd1));
    else pass_cnt++;
    tick(5);
    total_cnt++;
    if (obs !== mk(3'd4, 0, 0, 0, 4'd1))
      $display("FAIL rx_backoff1_last: got %h exp %h", obs, mk(3'd4, 0, 0, 0, 4'd1));
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd2, 1, 0, 0, 4'd1))
      $display("FAIL rx_start2: got %h exp %h", obs, mk(3'd2, 1, 0, 0, 4'd1));
    else pass_cnt++;
    tick(8);
    total_cnt++;
    if (obs !== mk(3'd4, 0, 0, 0, 4'd2))
      $display("FAIL rx_backoff2: got %h exp %h", obs, mk(3'd4, 0, 0, 0, 4'd2));
    else pass_cnt++;
    tick(6);
    total_cnt++;
    if (obs !== mk(3'd5, 0, 0, 1, 4'd2))
      $display("FAIL rx_fault: got %h exp %h", obs, mk(3'd5, 0, 0, 1, 4'd2));
    else pass_cnt++;
  endtask

  task automatic test_fault_clear;
    pwr_off = 1'b1;
    tick(2);
    total_cnt++;
    if (obs !== mk(3'd5, 0, 0, 1, 4'd2))
      $display("FAIL fc_pwr_off_ignored: got %h exp %h", obs, mk(3'd5, 0, 0, 1, 4'd2));
    else pass_cnt++;
    pwr_off = 1'b0;
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    total_cnt++;
    if (obs !== mk(3'd5, 0, 0, 1, 4'd2))
      $display("FAIL fc_clear_with_req: got %h exp %h", obs, mk(3'd5, 0, 0, 1, 4'd2));
    else pass_cnt++;
    pwr_req = 1'b0;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd5, 0, 0, 1, 4'd2))
      $display("FAIL fc_req_low_holds: got %h exp %h", obs, mk(3'd5, 0, 0, 1, 4'd2));
    else pass_cnt++;
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL fc_cleared: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
  endtask

  task automatic test_brownout_override;
    pwr_req = 1'b1;
    tick(5);
    mon_on = 1'b1;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd3, 1, 1, 0, 4'd0))
      $display("FAIL bo_on: got %h exp %h", obs, mk(3'd3, 1, 1, 0, 4'd0));
    else pass_cnt++;
    tick(2);
    mon_on = 1'b0;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd4, 0, 0, 0, 4'd1))
      $display("FAIL bo_backoff: got %h exp %h", obs, mk(3'd4, 0, 0, 0, 4'd1));
    else pass_cnt++;
    tick(5);
    total_cnt++;
    if (obs !== mk(3'd4, 0, 0, 0, 4'd1))
      $display("FAIL bo_backoff_last: got %h exp %h", obs, mk(3'd4, 0, 0, 0, 4'd1));
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd2, 1, 0, 0, 4'd1))
      $display("FAIL bo_restart: got %h exp %h", obs, mk(3'd2, 1, 0, 0, 4'd1));
    else pass_cnt++;
    pwr_off = 1'b1;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL ov_pwr_off_start: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
    tick(2);
    total_cnt++;
    if (state_dbg !== 3'd0)
      $display("FAIL ov_pwr_off_holds: got %0d exp %0d", state_dbg, 3'd0);
    else pass_cnt++;
    pwr_off = 1'b0; pwr_req = 1'b0;
    tick(1);
  endtask

  task automatic test_async_reset;
    pwr_req = 1'b1; mon_on = 1'b0;
    tick(13);
    tick(2);
    total_cnt++;
    if (obs !== mk(3'd4, 0, 0, 0, 4'd1))
      $display("FAIL ar_in_backoff: got %h exp %h", obs, mk(3'd4, 0, 0, 0, 4'd1));
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL ar_immediate: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
    pwr_req = 1'b0;
    #1;
    reset_n = 1'b1;
    tick(1);
    total_cnt++;
    if (obs !== mk(3'd0, 0, 0, 0, 4'd0))
      $display("FAIL ar_after_release: got %h exp %h", obs, mk(3'd0, 0, 0, 0, 4'd0));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal_powerup();
    test_glitch();
    test_retry_exhaustion();
    test_fault_clear();
    test_brownout_override();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
